// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and frame length, reporting static levels on timeout
module pwm_capture #(
  parameter int PERIOD  = 256,
  parameter int TIMEOUT = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inpt,
  output logic [7:0] duty,
  output logic [9:0] period,
  output logic       valid,
  output logic       period_err,
  output logic       stuck
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);
  localparam logic [9:0] PER      = 10'(PERIOD);
  state_t     state, state_nx;
  logic       s1, s2, s3;
  logic       rise, tmo;
  logic [9:0] high_cnt, per_cnt;
  // input synchronizer plus history flop for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {inpt, s1, s2};
  // rising edge beats a coincident timeout
  always_comb begin
    rise     = s2 & ~s3;
    tmo      = (per_cnt == TMO_LAST) & ~rise;
    state_nx = rise ? MEASURE : tmo ? IDLE : state;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // frame and high-time counters; restart on edge, clear on timeout, saturate otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      per_cnt  <= '0;
      high_cnt <= '0;
    end else if (rise) begin
      per_cnt  <= 10'd1;
      high_cnt <= 10'd1;
    end else if (tmo) begin
      per_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      per_cnt  <= (per_cnt == 10'h3ff) ? per_cnt : per_cnt + 10'd1;
      if (state == MEASURE && s2) high_cnt <= (high_cnt == 10'h3ff) ? high_cnt : high_cnt + 10'd1;
    end
  // report registers; the first edge after idle only arms the counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      duty       <= '0;
      period     <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise && state == MEASURE) begin
        duty       <= (high_cnt > 10'd255) ? 8'd255 : high_cnt[7:0];
        period     <= per_cnt;
        period_err <= per_cnt != PER;
        stuck      <= 1'b0;
        valid      <= 1'b1;
      end else if (tmo) begin
        duty       <= {8{s2}};
        period     <= '0;
        period_err <= 1'b1;
        stuck      <= 1'b1;
        valid      <= 1'b1;
      end
    end
endmodule
